// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes and the
// scan codes the game logic decodes from the keyboard.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  localparam logic [8:0] SPACE = 9'h029;
  localparam logic [8:0] W     = 9'h01D;
  localparam logic [8:0] A     = 9'h01C;
  localparam logic [8:0] S     = 9'h01B;
  localparam logic [8:0] D     = 9'h023;

  // Data byte with its odd-parity bit on top, in PS/2 bit order (LSB first).
  function automatic logic [8:0] frame_bits(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line, plus a one-cycle pulse on each
// falling edge of the synchronized level. Idle lines are high, so flops reset to 1.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta;
  logic level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta    <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      meta    <= din;
      level   <= meta;
      level_q <= level;
    end
  end

  assign fall = level_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clock out one command
// byte on device clocks, then check the device ACK. Pins are open-drain.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  tx_state_t     state, state_n;
  logic [8:0]    shift, shift_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] wdog, wdog_n;
  logic          ack_ok, ack_ok_n;
  logic          data_oe_n, done_n, err_n;
  logic          sync_clk, sync_data, fall, data_fall_unused;
  logic          watched, timeout;

  ps2_line_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk_i),
    .level(sync_clk),
    .fall (fall)
  );

  ps2_line_sync u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_data_i),
    .level(sync_data),
    .fall (data_fall_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift       <= '0;
      bitcnt      <= '0;
      icnt        <= '0;
      wdog        <= '0;
      ack_ok      <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      bitcnt      <= bitcnt_n;
      icnt        <= icnt_n;
      wdog        <= wdog_n;
      ack_ok      <= ack_ok_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  assign watched = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = watched && (wdog == TO_LAST);

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bitcnt_n  = bitcnt;
    icnt_n    = icnt;
    wdog_n    = '0;
    ack_ok_n  = ack_ok;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_n   = frame_bits(tx_data);
          state_n   = INHIBIT;
          icnt_n    = '0;
          bitcnt_n  = '0;
          data_oe_n = (INHIBIT_CYCLES < 2);
        end
      end
      INHIBIT: begin
        // Start bit goes low during the last inhibit cycle, before CLK is released.
        if (icnt == INH_LAST) begin
          state_n = SEND;
          icnt_n  = '0;
        end else begin
          icnt_n = icnt + IW'(1);
          if (icnt_n == INH_LAST) data_oe_n = 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          if (bitcnt < 4'd9) begin
            data_oe_n = ~shift[bitcnt];
            bitcnt_n  = bitcnt + 4'd1;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          ack_ok_n = ~sync_data;
          state_n  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          state_n = IDLE;
          done_n  = ack_ok;
          err_n   = ~ack_ok;
        end
      end
      default: state_n = IDLE;
    endcase

    if (watched && !fall && state_n == state) wdog_n = wdog + TW'(1);

    // Timeout overrides any edge seen in the same cycle.
    if (timeout) begin
      state_n   = IDLE;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b1;
      wdog_n    = '0;
    end
  end

  assign ps2_clk_oe = (state == INHIBIT);
  assign tx_ready   = (state == IDLE);
  assign busy       = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames out of the
// host and answers with or without ACK; expected frames are hand-computed.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int oe_cycles = 0, oe_rises = 0, err_cyc = 0, last_fall = 0;
  logic clk_oe_q = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) oe_cycles <= oe_cycles + 1;
    if (ps2_clk_oe && !clk_oe_q) oe_rises <= oe_rises + 1;
    clk_oe_q <= ps2_clk_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    ok = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1;
    end
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, then generate nf clock pulses,
  // sampling DATA while CLK is high; optionally pull DATA low for the ACK.
  task automatic dev_frame(input bit ack, input int nf, output logic [10:0] bits, output bit ok);
    bits = '0;
    ok   = 0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < nf; i++) begin
        repeat (HALF) @(negedge clk);
        bits[i] = ps2_data_i;
        if (i == 10 && ack) begin
          dev_data_low = 1'b1;
          repeat (2) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        last_fall   = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < TO + 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    int          nfalls;
    logic [10:0] bits;    // {stop, parity, data, start}, bit 0 first on the wire
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[4];
  logic [10:0] bits, mask;
  bit          ok;
  int          d0, e0, r0, dt;

  initial begin
    vecs[0] = '{8'hF4, 1'b1, 11, 11'h5E8, 1'b1, 1'b0};
    vecs[1] = '{8'hED, 1'b1, 11, 11'h7DA, 1'b1, 1'b0};
    vecs[2] = '{8'hF4, 1'b0, 11, 11'h5E8, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b1,  4, 11'h6B4, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_out", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_out", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);

    foreach (vecs[k]) begin
      d0 = done_cnt; e0 = err_cnt; r0 = oe_cycles;
      send_byte(vecs[k].data, ok);
      check("accept", ok, 1);
      check("ready_low_busy", {tx_ready, busy, ps2_clk_oe}, 3'b011);
      dev_frame(vecs[k].ack, vecs[k].nfalls, bits, ok);
      check("rts_seen", ok, 1);
      wait_idle(ok);
      check("idle_reached", ok, 1);
      repeat (3) @(negedge clk);
      mask = 11'((1 << vecs[k].nfalls) - 1);
      check("frame_bits", bits & mask, vecs[k].bits & mask);
      check("inhibit_len", oe_cycles - r0, INH);
      check("done_pulses", done_cnt - d0, vecs[k].exp_done);
      check("err_pulses", err_cnt - e0, vecs[k].exp_err);
      check("idle_lines", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
      if (vecs[k].nfalls < 11) begin
        dt = err_cyc - last_fall;
        check("timeout_latency", (dt >= TO && dt <= TO + 8), 1);
      end
    end

    // Reset in the middle of SEND: lines drop asynchronously, no pulse.
    send_byte(8'h12, ok);
    check("mid_accept", ok, 1);
    dev_frame(1'b1, 3, bits, ok);
    check("mid_bits", bits[2:0], 3'b100);
    check("mid_data_held", ps2_data_oe, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    #2 rst = 1'b0;
    #1 check("async_rel_send", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b0001);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);

    d0 = done_cnt; r0 = oe_cycles;
    send_byte(8'hFF, ok);
    dev_frame(1'b1, 11, bits, ok);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    check("ff_bits", bits, 11'h7FE);
    check("ff_done", done_cnt - d0, 1);
    check("ff_inhibit_len", oe_cycles - r0, INH);

    // Reset during INHIBIT releases CLK without waiting for an edge.
    send_byte(8'hF4, ok);
    repeat (50) @(negedge clk);
    check("inh_clk_low", ps2_clk_oe, 1'b1);
    #2 rst = 1'b0;
    #1 check("async_rel_inh", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // tx_valid held with a new byte while busy: accepted only once idle again.
    d0 = done_cnt; r0 = oe_rises;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hF4;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1;
    end
    tx_data = 8'hED;
    dev_frame(1'b1, 11, bits, ok);
    check("hold_first_bits", bits, 11'h5E8);
    check("hold_not_queued", oe_rises - r0, 1);
    wait_idle(ok);
    check("hold_idle", ok, 1);
    @(negedge clk);
    check("hold_reaccept", busy, 1'b1);
    tx_valid = 1'b0;
    dev_frame(1'b1, 11, bits, ok);
    check("hold_second_bits", bits, 11'h7DA);
    wait_idle(ok);
    repeat (5) @(negedge clk);
    check("hold_transfers", oe_rises - r0, 2);
    check("hold_done", done_cnt - d0, 2);
    check("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
